// File: rtl/lcd_reader_if.sv
// lcd_reader_if: CPU read handshake plus LCD pad signals for lcd_reader.
// master = requester/board side, slave = lcd_reader.
interface lcd_reader_if;
  logic       rd_req;
  logic       rd_rs;
  logic [3:0] sf_d_in;
  logic       busy;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_timeout;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       sf_drv_en;

  modport master (
    output rd_req, rd_rs, sf_d_in,
    input  busy, rd_valid, rd_data, rd_timeout, lcd_e, lcd_rs, lcd_rw, sf_drv_en
  );

  modport slave (
    input  rd_req, rd_rs, sf_d_in,
    output busy, rd_valid, rd_data, rd_timeout, lcd_e, lcd_rs, lcd_rw, sf_drv_en
  );
endinterface

// File: rtl/lcd_reader.sv
// lcd_reader: one HD44780 4-bit read (status or data byte) on request.
// Owns LCD_E/RS/RW during the read and asks the top level to tristate SF_D.
// Optional feature macro: LCD_RD_WAIT_EN -- data reads are preceded by
// busy-flag polling, with a POLL_MAX poll timeout reported on rd_timeout.
module lcd_reader #(
  parameter int T_SETUP  = 2,
  parameter int T_EHI    = 12,
  parameter int T_CYCLE  = 50,
  parameter int POLL_MAX = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  lcd_reader_if.slave bus
);

  // Cycle counter is 6 bits; reject parameter sets it cannot time.
  if (T_CYCLE > 63 || T_EHI < 1 || T_SETUP < 1 || T_CYCLE <= T_EHI ||
      POLL_MAX < 1 || POLL_MAX > 1024) begin : g_param_chk
    $error("lcd_reader: timing/poll parameters out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EHI, S_ELO, S_DONE} state_t;

  // Counter reload values: the counter runs down to 0 on the last cycle of a state.
  localparam logic [5:0] C_SETUP = 6'(T_SETUP - 1);
  localparam logic [5:0] C_EHI   = 6'(T_EHI - 1);
  localparam logic [5:0] C_ELO   = 6'(T_CYCLE - T_EHI - 1);

  state_t     r_state, w_state_nx;
  logic [5:0] r_cnt, w_cnt_nx;
  logic       r_nib, w_nib_nx;      // 0 = upper nibble, 1 = lower nibble
  logic       r_rs, w_rs_nx;        // RS of the access currently on the bus
  logic [7:0] r_shadow;             // byte being assembled
  logic       r_busy, r_valid, r_lcd_e, r_lcd_rs, r_lcd_rw, r_drv_en;
  logic [7:0] r_rd_data;

`ifdef LCD_RD_WAIT_EN
  logic       r_want, w_want_nx;    // request asked for a data byte
  logic [9:0] r_poll, w_poll_nx;    // BF=1 polls seen so far
  logic       r_to;
  logic       w_to_nx;
`endif

  // Next-state logic: sequence SETUP, two E windows, then DONE or another read.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_nib_nx   = r_nib;
    w_rs_nx    = r_rs;
`ifdef LCD_RD_WAIT_EN
    w_want_nx  = r_want;
    w_poll_nx  = r_poll;
    w_to_nx    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.rd_req) begin
          w_state_nx = S_SETUP;
          w_cnt_nx   = C_SETUP;
          w_nib_nx   = 1'b0;
`ifdef LCD_RD_WAIT_EN
          // Every request starts with a status access; data waits for BF=0.
          w_rs_nx    = 1'b0;
          w_want_nx  = bus.rd_rs;
          w_poll_nx  = '0;
`else
          w_rs_nx    = bus.rd_rs;
`endif
        end
      end
      S_SETUP: begin
        if (r_cnt == 6'd0) begin
          w_state_nx = S_EHI;
          w_cnt_nx   = C_EHI;
        end else begin
          w_cnt_nx = r_cnt - 6'd1;
        end
      end
      S_EHI: begin
        if (r_cnt == 6'd0) begin
          w_state_nx = S_ELO;
          w_cnt_nx   = C_ELO;
        end else begin
          w_cnt_nx = r_cnt - 6'd1;
        end
      end
      S_ELO: begin
        if (r_cnt != 6'd0) begin
          w_cnt_nx = r_cnt - 6'd1;
        end else if (!r_nib) begin
          // RS/RW unchanged, so the second nibble goes straight to E high.
          w_state_nx = S_EHI;
          w_cnt_nx   = C_EHI;
          w_nib_nx   = 1'b1;
        end else begin
          w_state_nx = S_DONE;
          w_cnt_nx   = '0;
          w_nib_nx   = 1'b0;
`ifdef LCD_RD_WAIT_EN
          if (r_want && !r_rs) begin
            if (!r_shadow[7]) begin
              // LCD ready: issue the data read.
              w_state_nx = S_SETUP;
              w_cnt_nx   = C_SETUP;
              w_rs_nx    = 1'b1;
            end else if (int'(r_poll) + 1 >= POLL_MAX) begin
              // Give up; report the last status byte.
              w_to_nx = 1'b1;
            end else begin
              w_state_nx = S_SETUP;
              w_cnt_nx   = C_SETUP;
              if (r_poll != '1) w_poll_nx = r_poll + 10'd1;
            end
          end
`endif
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_nib     <= 1'b0;
      r_rs      <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_lcd_e   <= 1'b0;
      r_lcd_rs  <= 1'b0;
      r_lcd_rw  <= 1'b0;
      r_drv_en  <= 1'b1;
      r_rd_data <= 8'h00;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_nib    <= w_nib_nx;
      r_rs     <= w_rs_nx;
      r_busy   <= (w_state_nx != S_IDLE);
      r_valid  <= (w_state_nx == S_DONE);
      r_lcd_e  <= (w_state_nx == S_EHI);
      r_lcd_rs <= (w_state_nx != S_IDLE) && w_rs_nx;
      r_lcd_rw <= (w_state_nx != S_IDLE);
      r_drv_en <= (w_state_nx == S_IDLE);
      if (w_state_nx == S_DONE) r_rd_data <= r_shadow;
    end
  end

  // Capture the pad nibble on the last E-high cycle into the shadow byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow <= 8'h00;
    end else if (r_state == S_EHI && r_cnt == 6'd0) begin
      if (r_nib) r_shadow[3:0] <= bus.sf_d_in;
      else       r_shadow[7:4] <= bus.sf_d_in;
    end
  end

`ifdef LCD_RD_WAIT_EN
  // Poll bookkeeping and the timeout qualifier for the DONE strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_want <= 1'b0;
      r_poll <= '0;
      r_to   <= 1'b0;
    end else begin
      r_want <= w_want_nx;
      r_poll <= w_poll_nx;
      r_to   <= (w_state_nx == S_DONE) && w_to_nx;
    end
  end
  assign bus.rd_timeout = r_to;
`else
  assign bus.rd_timeout = 1'b0;
`endif

  assign bus.busy      = r_busy;
  assign bus.rd_valid  = r_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.lcd_e     = r_lcd_e;
  assign bus.lcd_rs    = r_lcd_rs;
  assign bus.lcd_rw    = r_lcd_rw;
  assign bus.sf_drv_en = r_drv_en;

endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: table + random reads against a behavioural HD44780 model.
// The LCD model serves bytes from queues, drives junk outside the valid
// part of each E window, and logs every access, E pulse and rd_valid.
`timescale 1ns/1ps
module tb_lcd_reader;
`ifdef LCD_RD_WAIT_EN
  localparam int TB_POLL = 4;
  localparam bit WAIT    = 1'b1;
`else
  localparam int TB_POLL = 1000;
  localparam bit WAIT    = 1'b0;
`endif
  // Request edge to DONE edge for one read: setup + two full E periods.
  localparam int LAT = 2 + 2 * 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_reader_if bus();
  lcd_reader #(.T_SETUP(2), .T_EHI(12), .T_CYCLE(50), .POLL_MAX(TB_POLL)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus.slave)
  );

  typedef struct { int cyc; logic [7:0] data; logic to; } val_t;
  typedef struct { bit rs; logic [7:0] lcd_byte; logic [7:0] exp_data; } vec_t;

  logic [7:0] stat_q[$], data_q[$];
  logic [8:0] log_q[$];
  int         rise_q[$], width_q[$];
  val_t       val_q[$];
  int         n_cmp = 0, n_bad = 0;

  bit         prev_e = 1'b0, nib = 1'b0;
  int         hi_cnt = 0;
  logic [7:0] cur_byte = 8'h00;
  logic [3:0] nib_val, last_good = 4'h0;

  // LCD model and monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_e = 1'b0; nib = 1'b0; hi_cnt = 0;
      bus.sf_d_in = 4'h0;
    end else begin
      if (bus.lcd_e && !prev_e) begin
        hi_cnt = 1;
        rise_q.push_back(cyc);
        if (!nib) begin
          if (bus.lcd_rs) cur_byte = (data_q.size() != 0) ? data_q.pop_front() : 8'h00;
          else            cur_byte = (stat_q.size() != 0) ? stat_q.pop_front() : 8'h00;
          log_q.push_back({bus.lcd_rs, cur_byte});
        end
      end else if (bus.lcd_e) begin
        hi_cnt++;
      end
      if (!bus.lcd_e && prev_e) begin
        width_q.push_back(hi_cnt);
        nib = !nib;
      end
      if (!bus.lcd_rw) nib = 1'b0;
      nib_val = nib ? cur_byte[3:0] : cur_byte[7:4];
      if (bus.lcd_e && hi_cnt > 3) begin
        bus.sf_d_in = nib_val;
        last_good   = nib_val;
      end else if (bus.lcd_e) begin
        bus.sf_d_in = ~nib_val;
      end else begin
        bus.sf_d_in = ~last_good;
      end
      if (bus.rd_valid) val_q.push_back('{cyc, bus.rd_data, bus.rd_timeout});
      prev_e = bus.lcd_e;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    rise_q.delete(); width_q.delete(); val_q.delete(); log_q.delete();
  endtask

  function automatic int n_rs(input bit r);
    int c = 0;
    foreach (log_q[i]) if (log_q[i][8] == r) c++;
    return c;
  endfunction

  // Pulse rd_req for one edge; n0 is the cycle number of the sampling edge.
  task automatic start(input bit rs, output int n0);
    @(negedge clk);
    bus.rd_rs  = rs;
    bus.rd_req = 1'b1;
    @(negedge clk);
    n0 = cyc;
    bus.rd_req = 1'b0;
  endtask

  task automatic do_read(input string nm, input bit rs, input logic [7:0] b, input logic [7:0] exp);
    int n0, npoll, lat, bad_w;
    clr();
    if (rs) data_q.push_back(b); else stat_q.push_back(b);
    // With polling enabled, an empty status queue reads as 00 (ready): one poll.
    npoll = (WAIT && rs) ? 1 : 0;
    lat   = LAT * (npoll + 1);
    start(rs, n0);
    chk({nm, ".busy"}, bus.busy, 1);
    chk({nm, ".rw"}, bus.lcd_rw, 1);
    chk({nm, ".drv_en"}, bus.sf_drv_en, 0);
    chk({nm, ".lcd_rs"}, bus.lcd_rs, WAIT ? 1'b0 : rs);
    while (val_q.size() == 0 && cyc < n0 + lat + 20) @(negedge clk);
    if (val_q.size() == 0) begin
      chk({nm, ".valid_seen"}, 0, 1);
    end else begin
      chk({nm, ".latency"}, val_q[0].cyc - n0, lat);
      chk({nm, ".data"}, val_q[0].data, exp);
      chk({nm, ".timeout"}, val_q[0].to, 0);
    end
    repeat (2) @(negedge clk);
    chk({nm, ".n_valid"}, val_q.size(), 1);
    chk({nm, ".busy_after"}, bus.busy, 0);
    chk({nm, ".rw_after"}, bus.lcd_rw, 0);
    chk({nm, ".drv_after"}, bus.sf_drv_en, 1);
    chk({nm, ".data_held"}, bus.rd_data, exp);
    chk({nm, ".e_first"}, (rise_q.size() != 0) ? rise_q[0] - n0 : -1, 2);
    chk({nm, ".e_pitch"}, (rise_q.size() >= 2) ? rise_q[rise_q.size()-1] - rise_q[rise_q.size()-2] : -1, 50);
    bad_w = 0;
    foreach (width_q[i]) if (width_q[i] != 12) bad_w++;
    chk({nm, ".e_width_bad"}, bad_w, 0);
    chk({nm, ".e_pulses"}, width_q.size(), 2 * (npoll + 1));
    chk({nm, ".last_rs"}, (log_q.size() != 0) ? log_q[log_q.size()-1][8] : 1'bx, rs);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    int   n0;
    bit   rs;
    logic [7:0] b;

    tbl = '{'{1'b0, 8'h83, 8'h83}, '{1'b1, 8'hA5, 8'hA5},
            '{1'b0, 8'h00, 8'h00}, '{1'b1, 8'hFF, 8'hFF}};
    bus.rd_req = 1'b0;
    bus.rd_rs  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.busy", bus.busy, 0);
    chk("reset.valid", bus.rd_valid, 0);
    chk("reset.data", bus.rd_data, 8'h00);
    chk("reset.timeout", bus.rd_timeout, 0);
    chk("reset.e", bus.lcd_e, 0);
    chk("reset.rs", bus.lcd_rs, 0);
    chk("reset.rw", bus.lcd_rw, 0);
    chk("reset.drv_en", bus.sf_drv_en, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle.busy", bus.busy, 0);

    // Directed vectors; A5 exercises the sample point (junk after E falls is 5).
    for (int i = 0; i < 4; i++)
      do_read($sformatf("vec%0d", i), tbl[i].rs, tbl[i].lcd_byte, tbl[i].exp_data);

    // Requests while busy and in the DONE cycle are ignored.
    clr();
    stat_q.push_back(8'h3C);
    start(1'b0, n0);
    while (cyc < n0 + 19) @(negedge clk);
    bus.rd_req = 1'b1;
    @(negedge clk);
    bus.rd_req = 1'b0;
    while (cyc < n0 + LAT) @(negedge clk);
    chk("ign.valid_at_done", bus.rd_valid, 1);
    bus.rd_req = 1'b1;
    @(negedge clk);
    bus.rd_req = 1'b0;
    chk("ign.busy_after", bus.busy, 0);
    repeat (6) @(negedge clk);
    chk("ign.busy_stays_low", bus.busy, 0);
    chk("ign.n_valid", val_q.size(), 1);
    chk("ign.data", (val_q.size() != 0) ? val_q[0].data : 8'hxx, 8'h3C);
    chk("ign.n_access", log_q.size(), 1);

    // Random reads against the model.
    for (int i = 0; i < 6; i++) begin
      rs = 1'($urandom_range(0, 1));
      b  = 8'($urandom);
      do_read($sformatf("rnd%0d", i), rs, b, b);
    end

    // Reset during the 5th E-high cycle: outputs drop without a clock edge.
    clr();
    stat_q.push_back(8'hE7);
    start(1'b0, n0);
    while (cyc < n0 + 6) @(negedge clk);
    chk("rst.e_before", bus.lcd_e, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst.e_async", bus.lcd_e, 0);
    chk("rst.busy_async", bus.busy, 0);
    chk("rst.drv_async", bus.sf_drv_en, 1);
    chk("rst.rw_async", bus.lcd_rw, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (110) @(negedge clk);
    chk("rst.n_valid", val_q.size(), 0);
    chk("rst.data", bus.rd_data, 8'h00);
    chk("rst.busy", bus.busy, 0);
    stat_q.delete();

`ifdef LCD_RD_WAIT_EN
    // Three BF=1 polls, then ready, then the data byte.
    clr();
    stat_q = '{8'h80, 8'h8F, 8'hF0, 8'h00};
    data_q.push_back(8'h41);
    start(1'b1, n0);
    while (val_q.size() == 0 && cyc < n0 + 5 * LAT + 20) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("wait.n_valid", val_q.size(), 1);
    chk("wait.data", (val_q.size() != 0) ? val_q[0].data : 8'hxx, 8'h41);
    chk("wait.timeout", (val_q.size() != 0) ? val_q[0].to : 1'bx, 0);
    chk("wait.latency", (val_q.size() != 0) ? val_q[0].cyc - n0 : -1, 5 * LAT);
    chk("wait.n_status", n_rs(1'b0), 4);
    chk("wait.n_data", n_rs(1'b1), 1);

    // BF stuck at 1 for POLL_MAX polls: timeout with the last status byte.
    clr();
    stat_q = '{8'h80, 8'h81, 8'h82, 8'hC7};
    data_q.push_back(8'h99);
    start(1'b1, n0);
    while (val_q.size() == 0 && cyc < n0 + 6 * LAT) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("tmo.n_valid", val_q.size(), 1);
    chk("tmo.timeout", (val_q.size() != 0) ? val_q[0].to : 1'bx, 1);
    chk("tmo.data", (val_q.size() != 0) ? val_q[0].data : 8'hxx, 8'hC7);
    chk("tmo.latency", (val_q.size() != 0) ? val_q[0].cyc - n0 : -1, TB_POLL * LAT);
    chk("tmo.n_status", n_rs(1'b0), TB_POLL);
    chk("tmo.n_data", n_rs(1'b1), 0);
    chk("tmo.busy_after", bus.busy, 0);
    data_q.delete();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
